// File: rtl/control_sequencer.sv
// Hard-wired control sequencer for the 32-bit bus datapath: walks T0..T7 per instruction,
// stretching memory steps by MEM_WAIT cycles, with halt and instruction-boundary stop.
module control_sequencer #(
  parameter int unsigned MEM_WAIT = 1,
  parameter logic [4:0]  ADD_OP   = 5'b00011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        stop,
  output logic        read,
  output logic        write,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MARin,
  output logic        IRin,
  output logic        PCin,
  output logic        PCout,
  output logic        incPC,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        CONN_in,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLowOut,
  output logic [4:0]  alu_op,
  output logic        run
);

  typedef enum logic [3:0] {
    StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalted, StStopped
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  // Set by reset: holds the sequencer in T0 with all strobes low for one cycle.
  logic       blank_q, blank_d;

  logic [4:0] opcode;
  logic       is_rtype, is_imm, is_ldi, is_ld, is_st, is_br, is_halt;
  logic       mem_done;
  logic [4:0] imm_op;
  state_e     to_t0;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign is_rtype  = (opcode >= 5'b00011) && (opcode <= 5'b01011);
  assign is_imm    = (opcode >= 5'b01100) && (opcode <= 5'b01110);
  assign is_ldi    = (opcode == 5'b00001);
  assign is_ld     = (opcode == 5'b00000);
  assign is_st     = (opcode == 5'b00010);
  assign is_br     = (opcode == 5'b10010);
  assign is_halt   = (opcode == 5'b11011);
  assign mem_done  = (cnt_q == 3'(MEM_WAIT - 1));
  assign to_t0     = stop ? StStopped : StT0;

  always_comb begin
    unique case (opcode)
      5'b01100: imm_op = 5'b00011;
      5'b01101: imm_op = 5'b00101;
      default:  imm_op = 5'b00110;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    blank_d = 1'b0;
    case (state_q)
      StT0: state_d = blank_q ? to_t0 : StT1;
      StT1: begin
        if (mem_done) state_d = StT2;
        else          cnt_d   = cnt_q + 3'd1;
      end
      StT2: state_d = StT3;
      StT3: begin
        if (is_halt) begin
          state_d = StHalted;
        end else if (is_rtype || is_imm || is_ldi || is_ld || is_st || is_br) begin
          state_d = StT4;
        end else begin
          state_d = to_t0;
        end
      end
      StT4: state_d = StT5;
      StT5: state_d = (is_ld || is_st || is_br) ? StT6 : to_t0;
      StT6: begin
        if (is_ld) begin
          if (mem_done) state_d = StT7;
          else          cnt_d   = cnt_q + 3'd1;
        end else if (is_st) begin
          state_d = StT7;
        end else begin
          state_d = to_t0;
        end
      end
      StT7: begin
        if (is_st && !mem_done) cnt_d   = cnt_q + 3'd1;
        else                    state_d = to_t0;
      end
      StHalted:  state_d = StHalted;
      StStopped: state_d = stop ? StStopped : StT0;
      default:   state_d = StT0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= StT0;
      cnt_q   <= '0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
    end
  end

  assign run = (state_q != StHalted) && (state_q != StStopped);

  always_comb begin
    read    = 1'b0;
    write   = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    IRin    = 1'b0;
    PCin    = 1'b0;
    PCout   = 1'b0;
    incPC   = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    BAout   = 1'b0;
    Cout    = 1'b0;
    CONN_in = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    ZLowOut = 1'b0;
    alu_op  = 5'b00000;
    if (!blank_q) begin
      case (state_q)
        StT0: begin
          PCout = 1'b1;
          MARin = 1'b1;
          incPC = 1'b1;
        end
        StT1: begin
          read  = 1'b1;
          MDRin = 1'b1;
        end
        StT2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        StT3: begin
          if (is_rtype || is_imm) begin
            Grb  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end else if (is_ldi || is_ld || is_st) begin
            Grb   = 1'b1;
            BAout = 1'b1;
            Yin   = 1'b1;
          end else if (is_br) begin
            Gra     = 1'b1;
            Rout    = 1'b1;
            CONN_in = 1'b1;
          end
        end
        StT4: begin
          if (is_rtype) begin
            Grc    = 1'b1;
            Rout   = 1'b1;
            Zin    = 1'b1;
            alu_op = opcode;
          end else if (is_imm) begin
            Cout   = 1'b1;
            Zin    = 1'b1;
            alu_op = imm_op;
          end else if (is_ldi || is_ld || is_st) begin
            Cout   = 1'b1;
            Zin    = 1'b1;
            alu_op = ADD_OP;
          end else if (is_br) begin
            PCout = 1'b1;
            Yin   = 1'b1;
          end
        end
        StT5: begin
          if (is_rtype || is_imm || is_ldi) begin
            ZLowOut = 1'b1;
            Gra     = 1'b1;
            Rin     = 1'b1;
          end else if (is_ld || is_st) begin
            ZLowOut = 1'b1;
            MARin   = 1'b1;
          end else if (is_br) begin
            Cout   = 1'b1;
            Zin    = 1'b1;
            alu_op = ADD_OP;
          end
        end
        StT6: begin
          if (is_ld) begin
            read  = 1'b1;
            MDRin = 1'b1;
          end else if (is_st) begin
            Gra   = 1'b1;
            Rout  = 1'b1;
            MDRin = 1'b1;
          end else if (is_br && con) begin
            ZLowOut = 1'b1;
            PCin    = 1'b1;
          end
        end
        StT7: begin
          if (is_ld) begin
            MDRout = 1'b1;
            Gra    = 1'b1;
            Rin    = 1'b1;
          end else if (is_st) begin
            write = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (MEM_WAIT=1 and 3) checked cycle by cycle against
// per-instruction step lists built from the instruction-class rules.
module tb_control_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr1, clr3, con, stop;
  logic [31:0] ir;

  logic r1, w1, mi1, mo1, ma1, ii1, pi1, po1, ip1, ga1, gb1, gc1, ri1, ro1, ba1, co1, cn1, yi1,
        zi1, zl1, run1;
  logic r3, w3, mi3, mo3, ma3, ii3, pi3, po3, ip3, ga3, gb3, gc3, ri3, ro3, ba3, co3, cn3, yi3,
        zi3, zl3, run3;
  logic [4:0] alu1, alu3;

  control_sequencer #(.MEM_WAIT(1), .ADD_OP(5'b00011)) u_dut1 (
    .clk(clk), .clr(clr1), .ir(ir), .con(con), .stop(stop),
    .read(r1), .write(w1), .MDRin(mi1), .MDRout(mo1), .MARin(ma1), .IRin(ii1), .PCin(pi1),
    .PCout(po1), .incPC(ip1), .Gra(ga1), .Grb(gb1), .Grc(gc1), .Rin(ri1), .Rout(ro1),
    .BAout(ba1), .Cout(co1), .CONN_in(cn1), .Yin(yi1), .Zin(zi1), .ZLowOut(zl1),
    .alu_op(alu1), .run(run1)
  );

  control_sequencer #(.MEM_WAIT(3), .ADD_OP(5'b00011)) u_dut3 (
    .clk(clk), .clr(clr3), .ir(ir), .con(con), .stop(stop),
    .read(r3), .write(w3), .MDRin(mi3), .MDRout(mo3), .MARin(ma3), .IRin(ii3), .PCin(pi3),
    .PCout(po3), .incPC(ip3), .Gra(ga3), .Grb(gb3), .Grc(gc3), .Rin(ri3), .Rout(ro3),
    .BAout(ba3), .Cout(co3), .CONN_in(cn3), .Yin(yi3), .Zin(zi3), .ZLowOut(zl3),
    .alu_op(alu3), .run(run3)
  );

  // {run, alu_op, 20 strobes}
  logic [25:0] v1, v3;
  assign v1 = {run1, alu1, r1, w1, mi1, mo1, ma1, ii1, pi1, po1, ip1, ga1, gb1, gc1, ri1, ro1,
               ba1, co1, cn1, yi1, zi1, zl1};
  assign v3 = {run3, alu3, r3, w3, mi3, mo3, ma3, ii3, pi3, po3, ip3, ga3, gb3, gc3, ri3, ro3,
               ba3, co3, cn3, yi3, zi3, zl3};

  localparam logic [19:0] READ = 20'd1 << 19, WRITE = 20'd1 << 18, MDRIN = 20'd1 << 17;
  localparam logic [19:0] MDROUT = 20'd1 << 16, MARIN = 20'd1 << 15, IRIN = 20'd1 << 14;
  localparam logic [19:0] PCIN = 20'd1 << 13, PCOUT = 20'd1 << 12, INCPC = 20'd1 << 11;
  localparam logic [19:0] GRA = 20'd1 << 10, GRB = 20'd1 << 9, GRC = 20'd1 << 8;
  localparam logic [19:0] RIN = 20'd1 << 7, ROUT = 20'd1 << 6, BAOUT = 20'd1 << 5;
  localparam logic [19:0] COUT = 20'd1 << 4, CONNIN = 20'd1 << 3, YIN = 20'd1 << 2;
  localparam logic [19:0] ZIN = 20'd1 << 1, ZLOW = 20'd1;
  localparam logic [25:0] BLANK = 26'd1 << 25;
  localparam logic [25:0] IDLE  = 26'd0;
  localparam logic [4:0]  ADD   = 5'b00011;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit sel = 1'b0;
  int w = 1;
  logic [25:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [25:0] expv);
    logic [25:0] obs;
    obs = sel ? v3 : v1;
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s w=%0d cyc=%0d observed=%h expected=%h", tag, w, cyc, obs, expv);
    end
  endtask

  task automatic set_clr(input logic v);
    if (sel) clr3 = v;
    else     clr1 = v;
  endtask

  function automatic void push(input logic [19:0] s, input logic [4:0] a);
    exp_q.push_back({1'b1, a, s});
  endfunction

  // Expected per-cycle outputs of one instruction, from T0 through its last step.
  function automatic void build(input logic [4:0] op, input bit c, input int wt);
    exp_q.delete();
    push(PCOUT | MARIN | INCPC, 5'd0);
    for (int k = 0; k < wt; k++) push(READ | MDRIN, 5'd0);
    push(MDROUT | IRIN, 5'd0);
    if (op >= 3 && op <= 11) begin
      push(GRB | ROUT | YIN, 5'd0);
      push(GRC | ROUT | ZIN, op);
      push(ZLOW | GRA | RIN, 5'd0);
    end else if (op >= 12 && op <= 14) begin
      push(GRB | ROUT | YIN, 5'd0);
      push(COUT | ZIN, (op == 12) ? 5'd3 : (op == 13) ? 5'd5 : 5'd6);
      push(ZLOW | GRA | RIN, 5'd0);
    end else if (op == 1) begin
      push(GRB | BAOUT | YIN, 5'd0);
      push(COUT | ZIN, ADD);
      push(ZLOW | GRA | RIN, 5'd0);
    end else if (op == 0 || op == 2) begin
      push(GRB | BAOUT | YIN, 5'd0);
      push(COUT | ZIN, ADD);
      push(ZLOW | MARIN, 5'd0);
      if (op == 0) begin
        for (int k = 0; k < wt; k++) push(READ | MDRIN, 5'd0);
        push(MDROUT | GRA | RIN, 5'd0);
      end else begin
        push(GRA | ROUT | MDRIN, 5'd0);
        for (int k = 0; k < wt; k++) push(WRITE, 5'd0);
      end
    end else if (op == 18) begin
      push(GRA | ROUT | CONNIN, 5'd0);
      push(PCOUT | YIN, 5'd0);
      push(COUT | ZIN, ADD);
      push(c ? (ZLOW | PCIN) : 20'd0, 5'd0);
    end else begin
      push(20'd0, 5'd0);  // T3 of nop, undefined or halt
    end
  endfunction

  // Runs one instruction starting at the next edge (which must enter T0).
  task automatic run_instr(input logic [31:0] instr, input bit c, input int stop_at,
                           input int abort_at, input int stop_len);
    bit stopped = 1'b0;
    bit aborted = 1'b0;
    build(instr[31:27], c, w);
    for (int j = 0; j < exp_q.size(); j++) begin
      @(posedge clk); #1;
      check("step", exp_q[j]);
      if (j == 0) begin
        ir  = instr;
        con = c;
      end
      if (j == stop_at) begin
        stop = 1'b1;
        stopped = 1'b1;
      end
      if (j == abort_at) begin
        set_clr(1'b0);
        stop = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      @(posedge clk); #1;
      check("abort_blank", BLANK);
      set_clr(1'b1);
    end else if (instr[31:27] == 5'b11011) begin
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        check("halted", IDLE);
      end
      set_clr(1'b0);
      stop = 1'b0;
      @(posedge clk); #1;
      check("halt_clr_blank", BLANK);
      set_clr(1'b1);
    end else if (stopped) begin
      for (int k = 0; k < stop_len; k++) begin
        @(posedge clk); #1;
        check("stopped", IDLE);
        if (k == stop_len - 1) stop = 1'b0;
      end
    end
  endtask

  task automatic run_suite();
    logic [4:0] op;
    int sa;
    set_clr(1'b1);
    run_instr(32'h18918000, 1'b0, -1, -1, 0);           // add
    run_instr(32'h00A00010, 1'b0, -1, -1, 0);           // ld
    run_instr(32'h90800040, 1'b1, -1, -1, 0);           // branch taken
    run_instr(32'h90800040, 1'b0, -1, -1, 0);           // branch not taken
    run_instr(32'h61100005, 1'b0, w + 3, -1, 2);        // addi, stop raised in T4
    run_instr(32'h11000007, 1'b0, -1, -1, 0);           // st
    run_instr(32'hD0000000, 1'b0, -1, -1, 0);           // nop
    run_instr(32'h08800003, 1'b0, -1, -1, 0);           // ldi
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 9))
        0: op = 5'd0;
        1: op = 5'd1;
        2: op = 5'd2;
        3, 4: op = 5'($urandom_range(3, 11));
        5: op = 5'($urandom_range(12, 14));
        6, 7: op = 5'd18;
        8: op = 5'd26;
        default: op = 5'($urandom_range(19, 25));
      endcase
      sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      run_instr({op, 27'($urandom)}, 1'($urandom), sa, -1, int'($urandom_range(1, 3)));
    end
    run_instr(32'h11000007, 1'b0, -1, w + 5, 0);        // st aborted by clr in T6
    run_instr(32'h18918000, 1'b0, -1, -1, 0);
    run_instr(32'hD8000000, 1'b0, w + 1, -1, 0);        // halt with stop raised
    run_instr(32'h90800040, 1'b1, -1, -1, 0);
  endtask

  initial begin
    clr1 = 1'b0;
    clr3 = 1'b0;
    ir   = 32'h0;
    con  = 1'b0;
    stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0;
    w   = 1;
    check("reset_w1", BLANK);
    sel = 1'b1;
    w   = 3;
    check("reset_w3", BLANK);

    sel = 1'b0;
    w   = 1;
    run_suite();

    clr1 = 1'b0;
    sel  = 1'b1;
    w    = 3;
    run_suite();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hard-wired control unit for the 32-bit bus datapath.
- Walks fetch and execute steps T0..T7 for each instruction and drives the datapath's strobe inputs and the ALU opcode.
- Decodes IR[31:27] and samples the CON flip-flop result for branches.
- Stretches memory read/write steps for a configurable RAM latency, and supports halt and an external stop request.

Parameters:
MEM_WAIT, 1, cycles read or write is held in a memory step (legal range 1..7)
ADD_OP, 5'b00011, ALU opcode used for address and branch-target adds

Ports:
clk  in  1  system clock, rising edge
clr  in  1  synchronous active-low reset
ir  in  32  IR register contents; opcode = ir[31:27]
con  in  1  CONN_FF output (branch condition true)
stop  in  1  pause request, honoured at instruction boundary
read, write, MDRin, MDRout, MARin, IRin, PCin, PCout, incPC  out  1 each  datapath strobes
Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONN_in, Yin, Zin, ZLowOut  out  1 each  datapath strobes
alu_op  out  5  opcode to ALU
run  out  1  1 = executing; 0 = halted or stopped

Behaviour:
- Outputs are a Moore decode of the registered state. They are valid throughout a step and captured by the datapath at that step's closing edge.
- All strobes and alu_op are 0 outside the step lists below.
- Reset (clr=0 at an edge):
  - state <= T0, wait counter <= 0, run <= 1.
  - All strobes and alu_op are 0 in the following cycle.
  - Reset mid-instruction aborts it; nothing is written afterwards.
- Fetch, common to all instructions:
  - T0: PCout, MARin, incPC.
  - T1: read, MDRin, held MEM_WAIT cycles via the wait counter.
  - T2: MDRout, IRin.
- Decode: class is taken from ir[31:27] in T3. The IR updated at the T2 edge is valid from T3 onward.
- R-type, opcodes 00011..01011:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op=opcode.
  - T5: ZLowOut, Gra, Rin.
- Immediate, addi 01100 / andi 01101 / ori 01110:
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, alu_op=00011 / 00101 / 00110 respectively.
  - T5: ZLowOut, Gra, Rin.
- ldi 00001: as immediate, with BAout replacing Rout in T3 and alu_op=ADD_OP.
- ld 00000:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, alu_op=ADD_OP.
  - T5: ZLowOut, MARin.
  - T6: read, MDRin, for MEM_WAIT cycles.
  - T7: MDRout, Gra, Rin.
- st 00010:
  - T3..T5: same as ld.
  - T6: Gra, Rout, MDRin.
  - T7: write, for MEM_WAIT cycles.
- Branch 10010:
  - T3: Gra, Rout, CONN_in.
  - T4: PCout, Yin.
  - T5: Cout, Zin, alu_op=ADD_OP.
  - T6: if con=1 then ZLowOut, PCin; else no strobes.
  - con is sampled during T6, after its update at the T3 edge.
- nop 11010 and any undefined opcode: return to T0 after T3, with no strobes in T3.
- halt 11011:
  - In T3, state <= HALTED and run <= 0.
  - HALTED holds with all strobes 0 until clr.
- The last step of each class returns to T0 on the next edge.
- Wait counter:
  - Loads 0 on entry to a memory step and increments each cycle.
  - The step advances when count = MEM_WAIT-1.
  - With MEM_WAIT=1 a memory step lasts exactly one cycle.
- Stop:
  - If stop=1 at the edge that would enter T0, enter STOPPED instead (run=0, no strobes).
  - Leave STOPPED to T0 on the first edge with stop=0.
  - stop never interrupts an instruction in progress.
- Simultaneous events:
  - clr overrides stop and halt.
  - A halt decode with stop=1 goes to HALTED.
- Instruction latency with MEM_WAIT=W:
  - R-type and immediate: 5+W cycles.
  - ld and st: 6+2W cycles.
  - Branch: 6+W cycles.
  - nop: 3+W cycles.

Test Plan:
- Reset, then add (ir=0x18918000, opcode 00011) with MEM_WAIT=1 -> PCout/MARin/incPC in cycle 1. Rin with Gra in cycle 6, then T0 again. alu_op=00011 in T4 only.
- ld (opcode 00000) with MEM_WAIT=3 -> read high for exactly 3 consecutive cycles in T1 and 3 in T6. MDRout with Rin in T7. Total 12 cycles.
- Branch with con=1, then the same branch with con=0 -> PCin pulses once in T6 in the first case. PCin is never asserted in the second. Both return to T0 after 7 cycles.
- halt (0xD8000000) with stop=1 concurrently -> HALTED, run=0, all strobes 0 for 20 cycles. clr=0 for one edge -> T0 with run=1.
- stop=1 asserted during T4 of an addi (0x61100005) -> Gra/Rin still pulses in T5, then STOPPED (run=0). Deasserting stop -> PCout in the next cycle.
- clr=0 during T6 of st -> no write strobe in any later cycle. The next fetch begins with T0 one cycle after clr returns to 1.
